// File: rtl/debounce_pkg.sv
// Shared types and parameter limits for the debounce_edge input conditioner.
package debounce_pkg;

    typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} db_state_t;

    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;
    localparam int DB_MIN   = 2;
    localparam int DB_MAX   = 65535;

endpackage

// File: rtl/debounce_edge_sync_chain.sv
// Flop pipeline that brings an asynchronous level into the clk domain; output is the last stage.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronise, debounce and edge-detect a raw level input.
// Define DEBOUNCE_EDGE_CNT_EN to add the 8-bit edge_cnt rise counter output.
module debounce_edge
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d_in,
    output logic       q,
    output logic       rise,
    output logic       fall,
`ifdef DEBOUNCE_EDGE_CNT_EN
    output logic [7:0] edge_cnt,
`endif
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_badSync
        $error("debounce_edge: SYNC_STAGES out of range 2..4");
    end
    if (DEBOUNCE_CYCLES < DB_MIN || DEBOUNCE_CYCLES > DB_MAX) begin : g_badDb
        $error("debounce_edge: DEBOUNCE_CYCLES out of range 2..65535");
    end

    logic             w_s;
    db_state_t        r_state;
    db_state_t        w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_riseNext;
    logic             w_fallNext;
    logic             r_q;
    logic             r_rise;
    logic             r_fall;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d_in),
        .q   (w_s)
    );

    // A candidate change must hold for DEBOUNCE_CYCLES consecutive samples; any reversion aborts it.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_riseNext  = 1'b0;
        w_fallNext  = 1'b0;
        case (r_state)
            IDLE_LO: begin
                if (w_s) begin
                    w_stateNext = CHK_HI;
                    w_cntNext   = CNT_W'(1);
                end else begin
                    w_cntNext   = '0;
                end
            end
            CHK_HI: begin
                if (!w_s) begin
                    w_stateNext = IDLE_LO;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = IDLE_HI;
                    w_cntNext   = '0;
                    w_riseNext  = 1'b1;
                end else begin
                    w_cntNext   = r_cnt + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!w_s) begin
                    w_stateNext = CHK_LO;
                    w_cntNext   = CNT_W'(1);
                end else begin
                    w_cntNext   = '0;
                end
            end
            CHK_LO: begin
                if (w_s) begin
                    w_stateNext = IDLE_HI;
                    w_cntNext   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_stateNext = IDLE_LO;
                    w_cntNext   = '0;
                    w_fallNext  = 1'b1;
                end else begin
                    w_cntNext   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_stateNext = IDLE_LO;
                w_cntNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE_LO;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_q     <= (w_stateNext == IDLE_HI) || (w_stateNext == CHK_LO);
            r_rise  <= w_riseNext;
            r_fall  <= w_fallNext;
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;
    assign busy = (r_state == CHK_HI) || (r_state == CHK_LO);

`ifdef DEBOUNCE_EDGE_CNT_EN
    logic [7:0] r_edgeCnt;

    // Counts alongside the rise pulse register, so it wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edgeCnt <= 8'd0;
        end else if (w_riseNext) begin
            r_edgeCnt <= r_edgeCnt + 8'd1;
        end
    end

    assign edge_cnt = r_edgeCnt;
`endif

endmodule
